// File: rtl/ovdp_proc_pkg.sv
// Shared constants and state encoding for the averaging path
// (sample accumulator and downstream divide-by-N stage).
package ovdp_proc_pkg;

   localparam int SAMPLE_W = 13;   // unsigned input sample width
   localparam int SUM_W    = 16;   // group sum width, also the divider input width
   localparam int N_W      = 3;    // width of the group-size field
   localparam int N_MAX    = 7;    // largest group size

   // ACCUM: collecting samples; HOLD: finished group waiting for the output register
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage : ovdp_proc_pkg

// File: rtl/sample_group_accumulator.sv
// Sums groups of 1..7 consecutive samples and hands each group sum (with its
// sample count) to the divide-by-N stage over a valid/ready interface.
module sample_group_accumulator #(
   parameter int SAMPLE_W = ovdp_proc_pkg::SAMPLE_W,
   parameter int SUM_W    = ovdp_proc_pkg::SUM_W,
   parameter int ACC_W    = SUM_W + 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ovdp_proc_pkg::N_W-1:0] n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SAMPLE_W-1:0]           in_data,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SUM_W-1:0]              out_sum,
   output logic [ovdp_proc_pkg::N_W-1:0] out_n,
   output logic                          out_sat
);

   import ovdp_proc_pkg::*;

   // Largest value the output sum can carry, expressed at accumulator width
   localparam logic [ACC_W-1:0] SUM_MAX = {{(ACC_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

   // Clamp an accumulator value to the output width
   function automatic logic [SUM_W-1:0] clamp_sum(input logic [ACC_W-1:0] a);
      if (a > SUM_MAX) begin
         return {SUM_W{1'b1}};
      end
      return a[SUM_W-1:0];
   endfunction

   state_t               state_reg, state_next;
   logic [ACC_W-1:0]     acc_reg, acc_next;
   logic [N_W-1:0]       count_reg, count_next;
   logic [N_W-1:0]       n_l_reg, n_l_next;
   logic                 out_valid_reg, out_valid_next;
   logic [SUM_W-1:0]     out_sum_reg, out_sum_next;
   logic [N_W-1:0]       out_n_reg, out_n_next;
   logic                 out_sat_reg, out_sat_next;

   // Accumulator datapath view of "this cycle's sample applied"
   logic                 in_xfer;
   logic                 take;
   logic [ACC_W-1:0]     acc_upd;
   logic [N_W-1:0]       cnt_upd;
   logic [N_W-1:0]       nl_upd;
   logic                 group_done;
   logic                 out_xfer;
   logic                 out_free;

   // Ready drops combinationally with reset so nothing is taken while it is held
   assign in_ready  = ~reset & (state_reg == ACCUM);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid_reg & out_ready;
   assign out_free  = ~out_valid_reg | out_ready;

   assign out_valid = out_valid_reg;
   assign out_sum   = out_sum_reg;
   assign out_n     = out_n_reg;
   assign out_sat   = out_sat_reg;

   // Fold the accepted sample into the running group; n==0 at group start discards it
   always_comb begin
      take    = in_xfer & ~((count_reg == '0) & (n == '0));
      acc_upd = acc_reg;
      cnt_upd = count_reg;
      nl_upd  = n_l_reg;
      if (take) begin
         if (count_reg == '0) begin
            acc_upd = ACC_W'(in_data);
            cnt_upd = N_W'(1);
            nl_upd  = n;
         end else begin
            acc_upd = acc_reg + ACC_W'(in_data);
            cnt_upd = count_reg + N_W'(1);
         end
      end
      // A flush closes whatever is in the group, including a sample taken on the same edge
      group_done = (take & (cnt_upd == nl_upd)) | (flush & (cnt_upd != '0));
   end

   // Next-state logic: group completion, output register load and drain
   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      count_next     = count_reg;
      n_l_next       = n_l_reg;
      out_valid_next = out_valid_reg;
      out_sum_next   = out_sum_reg;
      out_n_next     = out_n_reg;
      out_sat_next   = out_sat_reg;

      if (out_xfer) begin
         out_valid_next = 1'b0;
      end

      case (state_reg)
         ACCUM: begin
            acc_next   = acc_upd;
            count_next = cnt_upd;
            n_l_next   = nl_upd;
            if (group_done) begin
               if (out_free) begin
                  out_valid_next = 1'b1;
                  out_sum_next   = clamp_sum(acc_upd);
                  out_sat_next   = (acc_upd > SUM_MAX);
                  out_n_next     = cnt_upd;
                  acc_next       = '0;
                  count_next     = '0;
               end else begin
                  // Keep the finished group in the accumulator until the consumer drains
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            // Only leave HOLD on the edge that frees the output register
            if (out_ready) begin
               out_valid_next = 1'b1;
               out_sum_next   = clamp_sum(acc_reg);
               out_sat_next   = (acc_reg > SUM_MAX);
               out_n_next     = count_reg;
               acc_next       = '0;
               count_next     = '0;
               state_next     = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ACCUM;
         acc_reg       <= '0;
         count_reg     <= '0;
         n_l_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_sum_reg   <= '0;
         out_n_reg     <= '0;
         out_sat_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         count_reg     <= count_next;
         n_l_reg       <= n_l_next;
         out_valid_reg <= out_valid_next;
         out_sum_reg   <= out_sum_next;
         out_n_reg     <= out_n_next;
         out_sat_reg   <= out_sat_next;
      end
   end

endmodule : sample_group_accumulator

// File: tb/tb_sample_group_accumulator.sv
// Scoreboard bench for sample_group_accumulator: a reference group model pushes
// expected results as samples are accepted; a monitor pops them on each output transfer.
module tb_sample_group_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [2:0]  out_n;
   logic        out_sat;

   // Second instance with 16-bit samples to reach saturation
   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] in_data16;
   logic        out_valid16;
   logic [15:0] out_sum16;
   logic [2:0]  out_n16;
   logic        out_sat16;

   int total = 0;
   int bad   = 0;
   int stall_cnt = 0;

   typedef struct {
      logic [15:0] sum;
      logic [2:0]  cnt;
      logic        sat;
   } exp_t;
   exp_t exp_q[$];

   // Reference group state
   int m_cnt = 0;
   int m_sum = 0;
   int m_nl  = 0;

   always #5 clk = ~clk;

   sample_group_accumulator dut (
      .clk(clk), .reset(reset), .n(n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_n(out_n), .out_sat(out_sat)
   );

   sample_group_accumulator #(.SAMPLE_W(16)) dut16 (
      .clk(clk), .reset(reset), .n(n),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
      .flush(1'b0),
      .out_valid(out_valid16), .out_ready(out_ready),
      .out_sum(out_sum16), .out_n(out_n16), .out_sat(out_sat16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic push_group();
      exp_t e;
      e.sum = (m_sum > 65535) ? 16'hFFFF : 16'(m_sum);
      e.sat = (m_sum > 65535);
      e.cnt = 3'(m_cnt);
      exp_q.push_back(e);
      m_cnt = 0;
      m_sum = 0;
   endtask

   // Drive one sample (optionally with flush) and wait until it is accepted
   task automatic send(input logic [12:0] d, input logic f);
      bit done = 0;
      in_data  = d;
      flush    = f;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            done = 1;
            if (!(m_cnt == 0 && n == 0)) begin
               if (m_cnt == 0) m_nl = n;
               m_sum += d;
               m_cnt++;
               if (m_cnt == m_nl || f) push_group();
            end
         end else begin
            stall_cnt++;
         end
      end
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   // Wait until every expected result has been transferred
   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: each transfer is compared with the oldest expected group
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", out_sum, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("xfer sum=%0d n=%0d sat=%0d (want %0d/%0d/%0d)",
                     out_sum, out_n, out_sat, e.sum, e.cnt, e.sat);
            chk("out_sum", out_sum, e.sum);
            chk("out_n",   out_n,   e.cnt);
            chk("out_sat", out_sat, e.sat);
         end
      end
   end

   initial begin
      reset = 1'b1; n = 3'd0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
      out_ready = 1'b1; in_valid16 = 1'b0; in_data16 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_n", out_n, 0);
      chk("rst_out_sat", out_sat, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // n=3, back-to-back samples, one-cycle latency
      n = 3'd3;
      stall_cnt = 0;
      send(13'd100, 0); send(13'd200, 0); send(13'd300, 0);
      chk("lat_valid", out_valid, 1);
      chk("lat_sum", out_sum, 600);
      chk("n3_no_stall", stall_cnt, 0);
      wait_drain();

      // n=7 full-scale samples
      n = 3'd7;
      for (int i = 0; i < 7; i++) send(13'd8191, 0);
      wait_drain();

      // n=2 with backpressure: first result held, second group goes to HOLD
      n = 3'd2;
      out_ready = 1'b0;
      send(13'd1, 0); send(13'd2, 0); send(13'd3, 0); send(13'd4, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", out_sum, 3);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      send(13'd5, 0); send(13'd6, 0);
      wait_drain();

      // n=5, flush together with the third sample, then flush on an empty group
      n = 3'd5;
      send(13'd10, 0); send(13'd20, 0); send(13'd30, 1);
      wait_drain();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("empty_flush_valid", out_valid, 0);
      @(posedge clk); #1;

      // n change mid-group is ignored; next groups use n=1 at full rate
      n = 3'd4;
      send(13'd1, 0); send(13'd2, 0);
      n = 3'd1;
      send(13'd3, 0); send(13'd4, 0);
      stall_cnt = 0;
      send(13'd5, 0); send(13'd6, 0); send(13'd7, 0);
      chk("n1_no_stall", stall_cnt, 0);
      wait_drain();

      // Reset mid-group discards the partial sum
      n = 3'd6;
      send(13'd1, 0); send(13'd2, 0); send(13'd3, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      m_cnt = 0; m_sum = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) send(13'(i * 10), 0);
      wait_drain();

      // Discard mode, then a group of one proves no state was left behind
      n = 3'd0;
      send(13'd55, 0);
      n = 3'd1;
      send(13'd9, 0);
      wait_drain();

      // 16-bit instance: seven 0xFFFF saturate the sum
      n = 3'd7;
      for (int i = 0; i < 7; i++) begin
         in_data16 = 16'hFFFF;
         in_valid16 = 1'b1;
         @(negedge clk);
         chk("w16_in_ready", in_ready16, 1);
         @(posedge clk); #1;
      end
      in_valid16 = 1'b0;
      @(negedge clk);
      chk("w16_valid", out_valid16, 1);
      chk("w16_sum", out_sum16, 16'hFFFF);
      chk("w16_sat", out_sat16, 1);
      chk("w16_n", out_n16, 7);
      $display("xfer w16 sum=%0d n=%0d sat=%0d", out_sum16, out_n16, out_sat16);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sample_group_accumulator
